// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared command/response codes and FSM state encoding for the UART command controller.
// No logic and no latency; imported by the controller and its sub-blocks.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_EXEC,
    ST_RD_WAIT,
    ST_REPLY
  } state_t;

  // An address byte is usable only if no bits above the register address width are set.
  function automatic logic addr_in_range(input logic [7:0] a, input int unsigned aw);
    return (aw >= 8) ? 1'b1 : ((a >> aw) == 8'd0);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte timeout: counts cycles while run is high, expired on the TIMEOUT-th counted cycle.
// One cycle from run to count; clear wins over run; no backpressure.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT = 1250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  logic [23:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  // Only meaningful while run is high, so a waiting byte always beats expiry.
  assign o_expired = i_run && (r_cnt == 24'(TIMEOUT - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses W/R command packets from an RX FIFO, drives a register port, pushes one reply byte.
// Byte pop to capture 2 cycles, capture to reg_wr 1 cycle, reg_wr to tx_wr 1 cycle; REPLY waits on tx_full.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1250000,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_empty,
  output logic              o_rx_rd,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wr,
  input  logic              i_tx_full,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy
);

  state_t              r_state;
  logic                r_cap;
  logic                r_is_wr;
  logic                r_addr_ok;
  logic                r_rx_rd;
  logic                r_tx_wr;
  logic                r_reg_wr;
  logic                r_reg_rd;
  logic                r_busy;
  logic [7:0]          r_tx_data;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [7:0]          r_reg_wdata;

  logic w_in_ad;
  logic w_to_run;
  logic w_to_clear;
  logic w_expired;

  // Timeout only guards the gap between bytes of a packet already started.
  assign w_in_ad    = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_to_run   = w_in_ad && i_rx_empty && !r_rx_rd && !r_cap;
  assign w_to_clear = !w_in_ad || r_rx_rd;

  uart_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (w_to_run),
    .i_clear   (w_to_clear),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cap       <= 1'b0;
      r_is_wr     <= 1'b0;
      r_addr_ok   <= 1'b0;
      r_rx_rd     <= 1'b0;
      r_tx_wr     <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_data   <= '0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_rx_rd  <= 1'b0;
      r_tx_wr  <= 1'b0;
      r_reg_wr <= 1'b0;
      r_reg_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_rx_empty) begin
            r_state <= ST_GET_CMD;
            r_busy  <= 1'b1;
          end
        end
        ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA: begin
          // Pop, wait one cycle for the FIFO output, then capture: one pop in flight at most.
          if (r_cap) begin
            r_cap <= 1'b0;
            if (r_state == ST_GET_CMD) begin
              if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
                r_is_wr <= (i_rx_data == CMD_WR);
                r_state <= ST_GET_ADDR;
              end else begin
                r_tx_data <= RSP_NAK;
                r_state   <= ST_REPLY;
              end
            end else if (r_state == ST_GET_ADDR) begin
              r_addr_ok <= addr_in_range(i_rx_data, ADDR_W);
              if (addr_in_range(i_rx_data, ADDR_W)) begin
                r_reg_addr <= i_rx_data[ADDR_W-1:0];
              end
              r_state <= r_is_wr ? ST_GET_DATA : ST_EXEC;
            end else begin
              r_reg_wdata <= i_rx_data;
              r_state     <= ST_EXEC;
            end
          end else if (r_rx_rd) begin
            r_cap <= 1'b1;
          end else if (!i_rx_empty) begin
            r_rx_rd <= 1'b1;
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (!r_addr_ok) begin
            r_tx_data <= RSP_NAK;
            r_state   <= ST_REPLY;
          end else if (r_is_wr) begin
            r_reg_wr  <= 1'b1;
            r_tx_data <= RSP_ACK;
            r_state   <= ST_REPLY;
          end else begin
            r_reg_rd <= 1'b1;
            r_state  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_cap) begin
            r_cap     <= 1'b0;
            r_tx_data <= i_reg_rdata;
            r_state   <= ST_REPLY;
          end else begin
            r_cap <= 1'b1;
          end
        end
        ST_REPLY: begin
          // Stay in REPLY through the push cycle so tx_wr is only ever seen with busy high.
          if (r_tx_wr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!i_tx_full) begin
            r_tx_wr <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_rd     = r_rx_rd;
  assign o_tx_wr     = r_tx_wr;
  assign o_tx_data   = r_tx_data;
  assign o_reg_wr    = r_reg_wr;
  assign o_reg_rd    = r_reg_rd;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table of packets, corner sequences, then random packets against a packet-level model.
module tb_uart_cmd_ctrl;

  localparam int TO = 50;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          rx_rd;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_full;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic [7:0]    reg_rdata;
  logic          busy;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_empty  (rx_empty),
    .o_rx_rd     (rx_rd),
    .o_tx_data   (tx_data),
    .o_tx_wr     (tx_wr),
    .i_tx_full   (tx_full),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_wr    (reg_wr),
    .o_reg_rd    (reg_rd),
    .i_reg_rdata (reg_rdata),
    .o_busy      (busy)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    logic [7:0] tx;
    int         nwr;
    logic [7:0] wa, wd;
    int         nrd;
    logic [7:0] ra;
  } row_t;

  logic [7:0]  rxq[$];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  regs[16];

  int n_vec = 0, n_miss = 0;
  int n_pop = 0, n_inv = 0, cyc = 0, last_wr = 0, last_tx = 0;
  logic          p_rx_rd = 1'b0, p_reg_rd = 1'b0;
  logic [AW-1:0] p_addr = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: the FIFO and register block react to last cycle's strobes, then this cycle's outputs are logged.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p_rx_rd) begin
      n_pop++;
      if (rxq.size() > 0) rx_data = rxq.pop_front();
    end
    if (p_reg_rd) reg_rdata = regs[p_addr];
    rx_empty = (rxq.size() == 0);
    if (reg_wr && reg_rd) n_inv++;
    if (rx_rd && rx_empty) n_inv++;
    if (tx_wr && !busy) n_inv++;
    if (reg_wr) begin
      regs[reg_addr] = reg_wdata;
      wr_log.push_back({8'(reg_addr), reg_wdata});
      last_wr = cyc;
    end
    if (reg_rd) rd_log.push_back(8'(reg_addr));
    if (tx_wr) begin
      tx_log.push_back(tx_data);
      last_tx = cyc;
    end
    p_rx_rd  = rx_rd;
    p_reg_rd = reg_rd;
    p_addr   = reg_addr;
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    int tx0, wr0, rd0, pop0;
    bit done;
    tx0 = tx_log.size(); wr0 = wr_log.size(); rd0 = rd_log.size(); pop0 = n_pop;
    done = 1'b0;
    push(r.b0);
    if (r.nb > 1) push(r.b1);
    if (r.nb > 2) push(r.b2);
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (tx_log.size() > tx0 && !busy) done = 1'b1;
    end
    chk("row_done", int'(done), 1);
    chk("row_pops", n_pop - pop0, r.nb);
    chk("row_ntx", tx_log.size() - tx0, 1);
    if (tx_log.size() > tx0) chk("row_txbyte", int'(tx_log[tx0]), int'(r.tx));
    chk("row_nwr", wr_log.size() - wr0, r.nwr);
    if (r.nwr > 0 && wr_log.size() > wr0) begin
      chk("row_waddr", int'(wr_log[wr0][15:8]), int'(r.wa));
      chk("row_wdata", int'(wr_log[wr0][7:0]), int'(r.wd));
      chk("row_wr2tx", last_tx - last_wr, 1);
    end
    chk("row_nrd", rd_log.size() - rd0, r.nrd);
    if (r.nrd > 0 && rd_log.size() > rd0) chk("row_raddr", int'(rd_log[rd0]), int'(r.ra));
    chk("row_invariants", n_inv, 0);
  endtask

  initial begin
    row_t       tbl[12];
    row_t       r2;
    logic [7:0] mregs[16];
    logic [7:0] exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    int tx0, wr0, rd0, pop0, t0, nlow, npk;
    bit done;
    logic [7:0] a, d, c;

    rst = 1'b1; rx_empty = 1'b1; tx_full = 1'b0; rx_data = '0; reg_rdata = '0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h80 + 8'(i);
    regs[5] = 8'h3C;

    tbl[0]  = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 1, 8'h03, 8'hA5, 0, 8'h00};
    tbl[1]  = '{8'h52, 8'h05, 8'h00, 2, 8'h3C, 0, 8'h00, 8'h00, 1, 8'h05};
    tbl[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[3]  = '{8'h57, 8'h20, 8'h11, 3, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[4]  = '{8'h52, 8'h10, 8'h00, 2, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[5]  = '{8'h57, 8'h0F, 8'hFF, 3, 8'h06, 1, 8'h0F, 8'hFF, 0, 8'h00};
    tbl[6]  = '{8'h52, 8'h0F, 8'h00, 2, 8'hFF, 0, 8'h00, 8'h00, 1, 8'h0F};
    tbl[7]  = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 0, 8'h00, 8'h00, 1, 8'h03};
    tbl[8]  = '{8'h52, 8'h00, 8'h00, 2, 8'h80, 0, 8'h00, 8'h00, 1, 8'h00};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[10] = '{8'h57, 8'h10, 8'h00, 3, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[11] = '{8'h52, 8'hFF, 8'h00, 2, 8'h15, 0, 8'h00, 8'h00, 0, 8'h00};

    for (int i = 0; i < 3; i++) step();
    chk("rst_rx_rd", int'(rx_rd), 0);
    chk("rst_tx_wr", int'(tx_wr), 0);
    chk("rst_reg_wr", int'(reg_wr), 0);
    chk("rst_reg_rd", int'(reg_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_reg_addr", int'(reg_addr), 0);
    chk("rst_reg_wdata", int'(reg_wdata), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_row(tbl[i]);

    // Stall after the address byte of a write: packet dropped silently.
    tx0 = tx_log.size(); wr0 = wr_log.size(); pop0 = n_pop;
    push(8'h57); push(8'h02);
    for (int i = 0; i < 50 && (n_pop - pop0) < 2; i++) step();
    t0 = cyc;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
    end
    chk("to_fired", int'(done), 1);
    chk("to_duration", int'((cyc - t0) >= TO && (cyc - t0) <= TO + 10), 1);
    chk("to_no_tx", tx_log.size() - tx0, 0);
    chk("to_no_wr", wr_log.size() - wr0, 0);
    r2 = '{8'h52, 8'h02, 8'h00, 2, 8'h82, 0, 8'h00, 8'h00, 1, 8'h02};
    run_row(r2);

    // Reply held off by a full TX FIFO.
    tx_full = 1'b1;
    tx0 = tx_log.size(); rd0 = rd_log.size();
    push(8'h52); push(8'h05);
    for (int i = 0; i < 50 && rd_log.size() == rd0; i++) step();
    nlow = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!busy) nlow++;
    end
    chk("full_no_tx", tx_log.size() - tx0, 0);
    chk("full_busy_low", nlow, 0);
    tx_full = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
    end
    chk("full_released", int'(done), 1);
    chk("full_ntx", tx_log.size() - tx0, 1);
    if (tx_log.size() > tx0) chk("full_txbyte", int'(tx_log[tx0]), 8'h3C);

    // Reset after the command byte of a write.
    tx0 = tx_log.size(); wr0 = wr_log.size(); pop0 = n_pop;
    push(8'h57);
    for (int i = 0; i < 20 && n_pop == pop0; i++) step();
    step(); step();
    rst = 1'b1;
    step();
    chk("mrst_strobes", int'({rx_rd, reg_wr, reg_rd, tx_wr}), 0);
    chk("mrst_busy", int'(busy), 0);
    rst = 1'b0;
    push(8'h01); push(8'h22);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (tx_log.size() - tx0 >= 2 && !busy) done = 1'b1;
    end
    chk("mrst_done", int'(done), 1);
    chk("mrst_no_wr", wr_log.size() - wr0, 0);
    chk("mrst_ntx", tx_log.size() - tx0, 2);
    if (tx_log.size() - tx0 >= 2) begin
      chk("mrst_nak0", int'(tx_log[tx0]), 8'h15);
      chk("mrst_nak1", int'(tx_log[tx0 + 1]), 8'h15);
    end

    // Random packet stream against a packet-level model.
    for (int i = 0; i < 16; i++) mregs[i] = regs[i];
    tx0 = tx_log.size(); wr0 = wr_log.size(); rd0 = rd_log.size();
    npk = 40;
    for (int k = 0; k < npk; k++) begin
      a = 8'($urandom_range(0, 19));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: begin
          push(8'h57); push(a); push(d);
          if (a < 8'(2 ** AW)) begin
            mregs[a[3:0]] = d;
            exp_wr.push_back({a, d});
            exp_tx.push_back(8'h06);
          end else exp_tx.push_back(8'h15);
        end
        1: begin
          push(8'h52); push(a);
          if (a < 8'(2 ** AW)) begin
            exp_rd.push_back(a);
            exp_tx.push_back(mregs[a[3:0]]);
          end else exp_tx.push_back(8'h15);
        end
        default: begin
          c = d;
          if (c == 8'h57 || c == 8'h52) c = c ^ 8'h01;
          push(c);
          exp_tx.push_back(8'h15);
        end
      endcase
    end
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      tx_full = ($urandom_range(0, 3) == 0);
      step();
      if (tx_log.size() - tx0 >= exp_tx.size() && !busy && rxq.size() == 0) done = 1'b1;
    end
    tx_full = 1'b0;
    chk("rnd_done", int'(done), 1);
    chk("rnd_ntx", tx_log.size() - tx0, exp_tx.size());
    chk("rnd_nwr", wr_log.size() - wr0, exp_wr.size());
    chk("rnd_nrd", rd_log.size() - rd0, exp_rd.size());
    for (int i = 0; i < exp_tx.size() && tx0 + i < tx_log.size(); i++)
      chk($sformatf("rnd_tx[%0d]", i), int'(tx_log[tx0 + i]), int'(exp_tx[i]));
    for (int i = 0; i < exp_wr.size() && wr0 + i < wr_log.size(); i++)
      chk($sformatf("rnd_wr[%0d]", i), int'(wr_log[wr0 + i]), int'(exp_wr[i]));
    for (int i = 0; i < exp_rd.size() && rd0 + i < rd_log.size(); i++)
      chk($sformatf("rnd_rd[%0d]", i), int'(rd_log[rd0 + i]), int'(exp_rd[i]));
    chk("rnd_invariants", n_inv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
